// File: rtl/gomoku_game_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gomoku_game_ctrl_pkg
// Brief   : State, side, judger and piece encodings shared by the game sequencer
// Revision: 1.0
// ============================================================================
package gomoku_game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_STOPPED  = 3'd0,
        ST_STARTING = 3'd1,
        ST_RESET    = 3'd2,
        ST_WAIT     = 3'd3,
        ST_JUDGE    = 3'd4,
        ST_END      = 3'd5
    } game_state_e;

    localparam logic [1:0] JUDGER_INVALID = 2'd0;
    localparam logic [1:0] JUDGER_VALID   = 2'd1;
    localparam logic [1:0] JUDGER_WIN     = 2'd2;

    localparam logic SIDE_RED   = 1'b0;
    localparam logic SIDE_GREEN = 1'b1;

    localparam logic [1:0] PIECE_RED   = 2'b01;
    localparam logic [1:0] PIECE_GREEN = 2'b10;

    function automatic logic [1:0] piece_of(input logic side);
        return (side == SIDE_GREEN) ? PIECE_GREEN : PIECE_RED;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gomoku_game_ctrl_turn_timer.sv
`default_nettype none
// ============================================================================
// Module  : turn_timer
// Brief   : 4-bit countdown with reload, tick-decrement and expire-at-zero
// Revision: 1.0
// ============================================================================
module turn_timer #(
    parameter logic [3:0] RELOAD = 4'd9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       reload_i,
    input  logic       tick_i,
    output logic [3:0] count_o,
    output logic       expire_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // A tick arriving at zero expires the turn and restarts the countdown.
    assign expire_o = tick_i & ~reload_i & (count_q == 4'd0);
    assign count_o  = count_q;

    always_comb begin
        count_d = count_q;
        if (reload_i || expire_o) begin
            count_d = RELOAD;
        end else if (tick_i) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RELOAD;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gomoku_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : gomoku_game_ctrl
// Brief   : N x N gomoku sequencer: turn FSM, cursor, board write-back, scores
// Revision: 1.0
// ============================================================================
module gomoku_game_ctrl
    import gomoku_game_ctrl_pkg::*;
#(
    parameter int EDGE_BITS  = 3,
    parameter int TURN_SECS  = 9,
    parameter int FLICKER_N  = 3,
    parameter int SCORE_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sw_power,
    input  logic                   btn_reset,
    input  logic                   btn_ok,
    input  logic                   sec_tick,
    input  logic                   flicker_fall,
    input  logic                   key_valid,
    input  logic [EDGE_BITS:0]     key_idx,
    output logic                   key_ready,
    output logic                   memrst_en,
    input  logic                   memrst_done,
    output logic                   judge_en,
    input  logic                   judge_done,
    input  logic [1:0]             judge_result,
    output logic                   ram_we,
    output logic [2*EDGE_BITS-1:0] ram_wr_addr,
    output logic [1:0]             ram_wr_data,
    output logic [2:0]             state,
    output logic                   active_side,
    output logic [2*EDGE_BITS-1:0] pos,
    output logic                   pos_valid,
    output logic [3:0]             num_countdown,
    output logic [SCORE_BITS-1:0]  red_wins,
    output logic [SCORE_BITS-1:0]  green_wins,
    output logic                   timeout_pulse
);

    localparam int AW    = 2 * EDGE_BITS;
    localparam int PW    = AW + 1;
    localparam int CELLS = 1 << AW;
    localparam int FW    = (FLICKER_N < 1) ? 1 : $clog2(FLICKER_N + 1);

    game_state_e           state_q, state_d;
    logic [2:0]            ok_sync_q;
    logic                  ok_edge;
    logic [FW-1:0]         flick_q, flick_d;
    logic                  side_q, side_d;
    logic [EDGE_BITS-1:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic                  x_vld_q, x_vld_d, y_vld_q, y_vld_d;
    logic [PW-1:0]         pieces_q, pieces_d;
    logic [SCORE_BITS-1:0] red_q, red_d, green_q, green_d;
    logic                  we_q, we_d;
    logic [AW-1:0]         wr_addr_q, wr_addr_d;
    logic [1:0]            wr_data_q, wr_data_d;
    logic                  key_ready_q, timeout_q;
    logic                  override, judge_hit;
    logic                  timer_tick, timer_reload, timer_expire;

    assign ok_edge      = ok_sync_q[1] & ~ok_sync_q[2];
    assign override     = ~sw_power | btn_reset;
    assign judge_hit    = (state_q == ST_JUDGE) & judge_done & ~override;
    assign timer_tick   = sec_tick & (state_q == ST_WAIT) & ~override;
    assign timer_reload = (state_q != ST_WAIT);

    turn_timer #(
        .RELOAD (4'(TURN_SECS))
    ) u_turn_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .reload_i (timer_reload),
        .tick_i   (timer_tick),
        .count_o  (num_countdown),
        .expire_o (timer_expire)
    );

    always_comb begin
        state_d   = state_q;
        flick_d   = (state_q == ST_STARTING) ? flick_q : '0;
        side_d    = side_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        x_vld_d   = x_vld_q;
        y_vld_d   = y_vld_q;
        pieces_d  = pieces_q;
        red_d     = red_q;
        green_d   = green_q;
        we_d      = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        unique case (state_q)
            ST_STOPPED: state_d = ST_STARTING;
            ST_STARTING: begin
                if (flicker_fall && (flick_q != FW'(FLICKER_N))) begin
                    flick_d = flick_q + 1'b1;
                end
                if (flick_q == FW'(FLICKER_N)) begin
                    state_d = ST_RESET;
                end
            end
            ST_RESET: begin
                side_d   = SIDE_RED;
                pieces_d = '0;
                {cur_x_d, cur_y_d, x_vld_d, y_vld_d} = '0;
                if (memrst_done) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (timer_expire) begin
                    side_d = ~side_q;
                    {cur_x_d, cur_y_d, x_vld_d, y_vld_d} = '0;
                end else if (ok_edge && x_vld_q && y_vld_q) begin
                    state_d = ST_JUDGE;
                end
            end
            ST_JUDGE: begin
                if (judge_hit) begin
                    state_d = ST_WAIT;
                    {cur_x_d, cur_y_d, x_vld_d, y_vld_d} = '0;
                    if (judge_result == JUDGER_VALID || judge_result == JUDGER_WIN) begin
                        we_d      = 1'b1;
                        wr_addr_d = {cur_y_q, cur_x_q};
                        wr_data_d = piece_of(side_q);
                    end
                    if (judge_result == JUDGER_WIN) begin
                        state_d = ST_END;
                        if (side_q == SIDE_GREEN) begin
                            green_d = (green_q == '1) ? green_q : green_q + 1'b1;
                        end else begin
                            red_d = (red_q == '1) ? red_q : red_q + 1'b1;
                        end
                    end else if (judge_result == JUDGER_VALID) begin
                        side_d   = ~side_q;
                        pieces_d = pieces_q + 1'b1;
                        if (pieces_q == PW'(CELLS - 1)) begin
                            state_d = ST_END;
                        end
                    end
                end
            end
            ST_END:  state_d = ST_END;
            default: state_d = ST_STOPPED;
        endcase

        if (!sw_power) begin
            state_d = ST_STOPPED;
        end else if (btn_reset) begin
            state_d = ST_RESET;
        end

        // Keys only land when the FSM stays in WAIT and the turn has not just expired.
        if ((state_q == ST_WAIT) && (state_d == ST_WAIT) && key_valid && !timer_expire) begin
            if (key_idx[EDGE_BITS]) begin
                cur_x_d = key_idx[EDGE_BITS-1:0];
                x_vld_d = 1'b1;
            end else begin
                cur_y_d = key_idx[EDGE_BITS-1:0];
                y_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_STOPPED;
            flick_q  <= '0;
            side_q   <= SIDE_RED;
            pieces_q <= '0;
        end else begin
            state_q  <= state_d;
            flick_q  <= flick_d;
            side_q   <= side_d;
            pieces_q <= pieces_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x_q <= '0;
            cur_y_q <= '0;
            x_vld_q <= 1'b0;
            y_vld_q <= 1'b0;
        end else begin
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            x_vld_q <= x_vld_d;
            y_vld_q <= y_vld_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_q   <= '0;
            green_q <= '0;
        end else begin
            red_q   <= red_d;
            green_q <= green_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            we_q      <= we_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_sync_q   <= '0;
            key_ready_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            ok_sync_q   <= {ok_sync_q[1:0], btn_ok};
            key_ready_q <= key_valid;
            timeout_q   <= timer_expire;
        end
    end

    assign state         = state_q;
    assign active_side   = side_q;
    assign pos           = {cur_y_q, cur_x_q};
    assign pos_valid     = x_vld_q & y_vld_q;
    assign memrst_en     = (state_q == ST_RESET);
    assign judge_en      = (state_q == ST_JUDGE);
    assign ram_we        = we_q;
    assign ram_wr_addr   = wr_addr_q;
    assign ram_wr_data   = wr_data_q;
    assign red_wins      = red_q;
    assign green_wins    = green_q;
    assign key_ready     = key_ready_q;
    assign timeout_pulse = timeout_q;

endmodule
`default_nettype wire
